// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the combinational ROM address and
// buffers {pc, instr} pairs in a small FIFO presented to IF/ID via valid/ready.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2,
    localparam int unsigned AW        = $clog2(FIFO_DEPTH),
    localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic [31:0]   rom_addr,
    input  logic [31:0]   rom_data,
    input  logic          halt,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          if_valid,
    input  logic          if_ready,
    output logic [31:0]   if_pc,
    output logic [31:0]   if_instr,
    output logic [CW-1:0] if_count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ZERO_C  = CW'(1'b0);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem_q    [FIFO_DEPTH];
    logic [31:0]   instr_mem_q [FIFO_DEPTH];
    logic          pop_s, push_s;
    logic [31:0]   target_s;

    // Handshake decode and next-state for fetch PC, pointers and occupancy.
    always_comb begin
        pop_s      = (count_q != ZERO_C) & if_ready & ~redirect_valid;
        push_s     = ~redirect_valid & ~halt & ((count_q < DEPTH_C) | pop_s);
        target_s   = redirect_pc & 32'hFFFF_FFFC;
        fetch_pc_d = fetch_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            // Redirect discards every buffered word, including any in-flight pop.
            fetch_pc_d = target_s;
            wr_ptr_d   = AW'(1'b0);
            rd_ptr_d   = AW'(1'b0);
            count_d    = ZERO_C;
        end else begin
            if (push_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = wr_ptr_q + AW'(1'b1);
            end else begin
                fetch_pc_d = fetch_pc_q;
                wr_ptr_d   = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1'b1);
                2'b01:   count_d = count_q - CW'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            wr_ptr_q   <= AW'(1'b0);
            rd_ptr_q   <= AW'(1'b0);
            count_q    <= ZERO_C;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entry storage; written only on push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem_q[i]    <= 32'h0000_0000;
                instr_mem_q[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
            instr_mem_q[wr_ptr_q] <= rom_data;
        end else begin
            pc_mem_q[wr_ptr_q]    <= pc_mem_q[wr_ptr_q];
            instr_mem_q[wr_ptr_q] <= instr_mem_q[wr_ptr_q];
        end
    end

    // Outputs are taken straight from registers, so if_ready/redirect never reach them combinationally.
    assign rom_addr = fetch_pc_q;
    assign if_valid = (count_q != ZERO_C);
    assign if_count = count_q;
    assign if_pc    = pc_mem_q[rd_ptr_q];
    assign if_instr = instr_mem_q[rd_ptr_q];

endmodule
